// File: rtl/drv_ad56x3_parm_mc.sv
// drv_ad56x3_parm_mc: double-buffered multi-channel parameter bank for the AD56x3 DAC driver.
// Software writes the shadow bank over Avalon-MM; a commit copies it atomically into the active bank.
module drv_ad56x3_parm_mc #(
    parameter int CH_NUM             = 4,
    parameter int DATA_W             = 16,
    parameter int ADR_W              = 5,
    parameter int DEFAULT_CE_DIVIDER = 125,
    parameter int DEFAULT_INCR_RATE  = 1
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic [ADR_W-1:0]         avsAdr,
    input  logic                     avsWr,
    input  logic [DATA_W-1:0]        avsWrData,
    input  logic                     avsRd,
    output logic [DATA_W-1:0]        avsRdData,
    output logic                     avsRdValid,
    input  logic                     frameStrb,
    output logic [CH_NUM-1:0]        genSel,
    output logic [2:0]               chRot,
    output logic [DATA_W-1:0]        ceDivider,
    output logic [CH_NUM*DATA_W-1:0] incrRate,
    output logic                     cfgUpdate,
    output logic                     cmdPending
);

    localparam int RA_W = ADR_W - 1;

    localparam logic [RA_W-1:0] A_CTRL   = RA_W'(0);
    localparam logic [RA_W-1:0] A_GENSEL = RA_W'(1);
    localparam logic [RA_W-1:0] A_CHROT  = RA_W'(2);
    localparam logic [RA_W-1:0] A_CEDIV  = RA_W'(3);
    localparam int              A_INCR0  = 8;

    // A zero divider would stall the generator, so even the default is clamped.
    localparam logic [DATA_W-1:0] DEF_CEDIV    = (DEFAULT_CE_DIVIDER == 0) ? DATA_W'(1)
                                                                           : DATA_W'(DEFAULT_CE_DIVIDER);
    localparam logic [DATA_W-1:0] DEF_INCR_POS = DATA_W'(DEFAULT_INCR_RATE);
    localparam logic [DATA_W-1:0] DEF_INCR_NEG = DATA_W'(0 - DEFAULT_INCR_RATE);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [RA_W-1:0]   w_reg_adr;
    logic              w_rd_active;
    logic              w_wr_ctrl;
    logic              w_wr_gensel;
    logic              w_wr_chrot;
    logic              w_wr_cediv;
    logic [CH_NUM-1:0] w_wr_incr;
    logic              w_chrot_ok;
    logic              w_soft;
    logic              w_imm;
    logic              w_arm;
    logic              w_strb_commit;
    logic              w_commit;

    logic [CH_NUM-1:0] r_sh_gensel;
    logic [CH_NUM-1:0] r_ac_gensel;
    logic [2:0]        r_sh_chrot;
    logic [2:0]        r_ac_chrot;
    logic [DATA_W-1:0] r_sh_cediv;
    logic [DATA_W-1:0] r_ac_cediv;
    logic [DATA_W-1:0] w_sh_incr [CH_NUM];
    logic [DATA_W-1:0] w_ac_incr [CH_NUM];

    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_cfg_update;

    // Address decode: the top address bit only selects the read bank, writes ignore it.
    assign w_reg_adr   = avsAdr[RA_W-1:0];
    assign w_rd_active = avsAdr[ADR_W-1];

    assign w_wr_ctrl   = avsWr && (w_reg_adr == A_CTRL);
    assign w_wr_gensel = avsWr && (w_reg_adr == A_GENSEL);
    assign w_wr_chrot  = avsWr && (w_reg_adr == A_CHROT);
    assign w_wr_cediv  = avsWr && (w_reg_adr == A_CEDIV);
    assign w_chrot_ok  = (avsWrData < DATA_W'(CH_NUM));

    // CTRL priority: soft reset > immediate commit > arm.
    assign w_soft        = w_wr_ctrl && avsWrData[0];
    assign w_imm         = w_wr_ctrl && avsWrData[2] && !avsWrData[0];
    assign w_arm         = w_wr_ctrl && avsWrData[1] && !avsWrData[2] && !avsWrData[0];
    assign w_strb_commit = (r_state == S_ARMED) && frameStrb && !w_soft;
    assign w_commit      = w_imm || w_strb_commit;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_arm)     w_state_next = S_ARMED;
            S_ARMED: if (frameStrb) w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
        if (w_soft || w_imm) begin
            w_state_next = S_IDLE;
        end
    end

    // Commit samples the shadow with non-blocking reads, so a same-cycle
    // shadow write lands in shadow only and waits for the next commit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sh_gensel <= '0;
            r_ac_gensel <= '0;
            r_sh_chrot  <= '0;
            r_ac_chrot  <= '0;
            r_sh_cediv  <= DEF_CEDIV;
            r_ac_cediv  <= DEF_CEDIV;
        end else if (w_soft) begin
            r_sh_gensel <= '0;
            r_ac_gensel <= '0;
            r_sh_chrot  <= '0;
            r_ac_chrot  <= '0;
            r_sh_cediv  <= DEF_CEDIV;
            r_ac_cediv  <= DEF_CEDIV;
        end else begin
            if (w_wr_gensel) begin
                r_sh_gensel <= avsWrData[CH_NUM-1:0];
            end
            if (w_wr_chrot && w_chrot_ok) begin
                r_sh_chrot <= avsWrData[2:0];
            end
            if (w_wr_cediv) begin
                r_sh_cediv <= (avsWrData == '0) ? DATA_W'(1) : avsWrData;
            end
            if (w_commit) begin
                r_ac_gensel <= r_sh_gensel;
                r_ac_chrot  <= r_sh_chrot;
                r_ac_cediv  <= r_sh_cediv;
            end
        end
    end

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        // Even channels count up, odd channels count down by default.
        localparam logic [DATA_W-1:0] DEF_INCR = ((gi % 2) == 0) ? DEF_INCR_POS : DEF_INCR_NEG;

        logic [DATA_W-1:0] r_sh_incr;
        logic [DATA_W-1:0] r_ac_incr;

        assign w_wr_incr[gi] = avsWr && (w_reg_adr == RA_W'(A_INCR0 + gi));

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                r_sh_incr <= DEF_INCR;
                r_ac_incr <= DEF_INCR;
            end else if (w_soft) begin
                r_sh_incr <= DEF_INCR;
                r_ac_incr <= DEF_INCR;
            end else begin
                if (w_wr_incr[gi]) begin
                    r_sh_incr <= avsWrData;
                end
                if (w_commit) begin
                    r_ac_incr <= r_sh_incr;
                end
            end
        end

        assign w_sh_incr[gi]                   = r_sh_incr;
        assign w_ac_incr[gi]                   = r_ac_incr;
        assign incrRate[gi*DATA_W +: DATA_W]   = r_ac_incr;
    end

    // Read mux sees pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        w_rd_data = '0;
        case (w_reg_adr)
            A_CTRL:   w_rd_data[1]          = (r_state == S_ARMED);
            A_GENSEL: w_rd_data[CH_NUM-1:0] = w_rd_active ? r_ac_gensel : r_sh_gensel;
            A_CHROT:  w_rd_data[2:0]        = w_rd_active ? r_ac_chrot : r_sh_chrot;
            A_CEDIV:  w_rd_data             = w_rd_active ? r_ac_cediv : r_sh_cediv;
            default: begin
                for (int k = 0; k < CH_NUM; k++) begin
                    if (w_reg_adr == RA_W'(A_INCR0 + k)) begin
                        w_rd_data = w_rd_active ? w_ac_incr[k] : w_sh_incr[k];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_cfg_update <= 1'b0;
        end else begin
            if (avsRd) begin
                r_rd_data <= w_rd_data;
            end
            r_rd_valid   <= avsRd;
            r_cfg_update <= w_commit || w_soft;
        end
    end

    assign avsRdData  = r_rd_data;
    assign avsRdValid = r_rd_valid;
    assign genSel     = r_ac_gensel;
    assign chRot      = r_ac_chrot;
    assign ceDivider  = r_ac_cediv;
    assign cfgUpdate  = r_cfg_update;
    assign cmdPending = (r_state == S_ARMED);

endmodule
